// File: rtl/fb_pkg.sv
// Shared framebuffer constants and types.
//   RESOLUTION_X / RESOLUTION_Y : framebuffer geometry in pixels
//   PALETTE_LENGTH              : palette entries, sets the pixel value width PW
//   FB_DEPTH                    : default write-buffer depth
//   fb_entry_t                  : one queued pixel write {linear address, value}
//   pixel_addr()                : (x,y) -> linear RAM address, row-major
package fb_pkg;

  localparam int RESOLUTION_X   = 400;
  localparam int RESOLUTION_Y   = 300;
  localparam int PALETTE_LENGTH = 256;
  localparam int FB_DEPTH       = 16;

  localparam int XW = $clog2(RESOLUTION_X);
  localparam int YW = $clog2(RESOLUTION_Y);
  localparam int PW = $clog2(PALETTE_LENGTH);
  localparam int AW = $clog2(RESOLUTION_X * RESOLUTION_Y);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [PW-1:0] value;
  } fb_entry_t;

  // The multiply is carried out at full address width so the largest
  // in-range coordinate pair cannot wrap.
  function automatic logic [AW-1:0] pixel_addr(input logic [XW-1:0] x,
                                               input logic [YW-1:0] y);
    return AW'(y) * AW'(RESOLUTION_X) + AW'(x);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-array synchronous FIFO.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request and data; ignored when full unless popping too
//   pop, dout  : read request; dout is the combinational head entry
//   level      : registered occupancy 0..DEPTH
//   full/empty : derived from wrap-bit pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW:0]      wr_ptr;
  logic [IW:0]      rd_ptr;
  logic [IW:0]      level_q;
  logic             push_ok;
  logic             pop_ok;

  // Pointers carry one extra wrap bit: equal indices with differing wrap
  // bits means full, fully equal pointers means empty.
  assign full    = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr[IW-1:0]];
  assign level   = level_q;

  // Storage needs no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[IW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (IW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (IW+1)'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + (IW+1)'(1);
        2'b01:   level_q <= level_q - (IW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/fb_write_buffer.sv
// Framebuffer write buffer between the core pixel write port and a
// single-port framebuffer RAM. Pixel writes are queued and drained to RAM
// only in cycles where scanout is not reading; scanout always wins the port.
//   clk, reset        : clock, synchronous active-high reset
//   fb_wr_*           : core pixel write strobe, coordinates and palette index
//   scan_rd_en/addr   : scanout read request and linear address
//   scan_rd_data      : RAM read data passed straight through to scanout
//   ram_addr/wr_data/wr_en, ram_rd_data : single-port RAM interface
//   clear_status      : clears overflow, oob and drop_count
//   level             : queue occupancy
//   overflow, oob     : sticky full-drop and out-of-range flags
//   drop_count        : saturating count of writes dropped while full
module fb_write_buffer
  import fb_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fb_wr_en,
  input  logic [XW-1:0]          fb_wr_pxl_x,
  input  logic [YW-1:0]          fb_wr_pxl_y,
  input  logic [PW-1:0]          fb_wr_pxl_value,
  input  logic                   scan_rd_en,
  input  logic [AW-1:0]          scan_rd_addr,
  output logic [PW-1:0]          scan_rd_data,
  output logic [AW-1:0]          ram_addr,
  output logic [PW-1:0]          ram_wr_data,
  output logic                   ram_wr_en,
  input  logic [PW-1:0]          ram_rd_data,
  input  logic                   clear_status,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   oob,
  output logic [15:0]            drop_count
);

  fb_entry_t push_entry;
  fb_entry_t head;
  logic      in_range;
  logic      push_req;
  logic      push_ok;
  logic      pop;
  logic      drop;
  logic      oob_evt;
  logic      full;
  logic      empty;

  // One spare bit on the compare keeps the check correct even if a
  // resolution is ever an exact power of two.
  assign in_range = ({1'b0, fb_wr_pxl_x} < (XW+1)'(RESOLUTION_X)) &&
                    ({1'b0, fb_wr_pxl_y} < (YW+1)'(RESOLUTION_Y));

  assign oob_evt  = fb_wr_en && !in_range;
  assign push_req = fb_wr_en && in_range;
  assign pop      = !scan_rd_en && !empty && !reset;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && !push_ok;

  assign push_entry.addr  = pixel_addr(fb_wr_pxl_x, fb_wr_pxl_y);
  assign push_entry.value = fb_wr_pxl_value;

  sync_fifo #(
    .WIDTH($bits(fb_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // The RAM port belongs to scanout unless a queued write is draining.
  always_comb begin
    ram_wr_en   = 1'b0;
    ram_addr    = scan_rd_addr;
    ram_wr_data = '0;
    if (pop) begin
      ram_wr_en   = 1'b1;
      ram_addr    = head.addr;
      ram_wr_data = head.value;
    end
  end

  assign scan_rd_data = ram_rd_data;

  // A clear in the same cycle as a new event still records that event.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      oob        <= 1'b0;
      drop_count <= '0;
    end else if (clear_status) begin
      overflow   <= drop;
      oob        <= oob_evt;
      drop_count <= drop ? 16'd1 : 16'd0;
    end else begin
      overflow <= overflow | drop;
      oob      <= oob | oob_evt;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

endmodule
